// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA colour output path.
package vga_pkg;

  typedef enum logic [1:0] {
    BRIGHT     = 2'd0,
    FADING_OUT = 2'd1,
    DARK       = 2'd2,
    FADING_IN  = 2'd3
  } fade_state_t;

  localparam bit SYNC_POL_DEFAULT = 1'b0;
  localparam int MAX_COLOR_W      = 16;
  localparam int COLOR_IDX_W      = $clog2(MAX_COLOR_W);

  // Replicates an in_w-bit code MSB-first across out_w bits (result in the low out_w bits).
  function automatic logic [MAX_COLOR_W-1:0] expand_color(
    input logic [MAX_COLOR_W-1:0] code,
    input int                     in_w,
    input int                     out_w
  );
    logic [MAX_COLOR_W-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_COLOR_W; i++) begin
      if (i < out_w && in_w > 0) begin
        res[COLOR_IDX_W'(out_w - 1 - i)] = code[COLOR_IDX_W'(in_w - 1 - (i % in_w))];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_fade_ctrl.sv
// Frame-synchronous brightness fade controller: vsync edge detect, frame counter,
// fade state machine and the current brightness level.
module vga_fade_ctrl
  import vga_pkg::*;
#(
  parameter int LVL_W       = 3,
  parameter int FADE_FRAMES = 4,
  parameter bit SYNC_POL    = SYNC_POL_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vsync_in,
  input  logic           fade_out_req,
  input  logic           fade_in_req,
  output logic [LVL_W:0] level,
  output logic           fade_busy
);

  localparam logic [LVL_W:0] FULL     = (LVL_W + 1)'(1 << LVL_W);
  localparam int             CNT_W    = $clog2(FADE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

  fade_state_t      state_q, state_d;
  logic [LVL_W:0]   level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vs_act_q;
  logic             vs_act;
  logic             tick;
  logic             take_out;
  logic             take_in;

  // The previous-sample flag resets to "active" so a vsync held active through
  // reset release must first be seen inactive before a tick can fire.
  assign vs_act = (vsync_in == SYNC_POL);
  assign tick   = vs_act && !vs_act_q;

  assign take_out = fade_out_req && (state_q == BRIGHT || state_q == FADING_IN);
  assign take_in  = fade_in_req && !fade_out_req &&
                    (state_q == DARK || state_q == FADING_OUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BRIGHT;
      level_q  <= FULL;
      cnt_q    <= '0;
      vs_act_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      vs_act_q <= vs_act;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (take_out) begin
      cnt_d   = '0;
      state_d = (level_q == '0) ? DARK : FADING_OUT;
    end else if (take_in) begin
      cnt_d   = '0;
      state_d = (level_q == FULL) ? BRIGHT : FADING_IN;
    end else if (tick && (state_q == FADING_OUT || state_q == FADING_IN)) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (state_q == FADING_OUT) begin
          level_d = level_q - 1'b1;
          if (level_q == (LVL_W + 1)'(1)) state_d = DARK;
        end else begin
          level_d = level_q + 1'b1;
          if (level_q == FULL - 1'b1) state_d = BRIGHT;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level     = level_q;
  assign fade_busy = (state_q == FADING_OUT) || (state_q == FADING_IN);

endmodule

// File: rtl/vga_color_stage.sv
// Two-stage colour output pipeline: bit-replication expansion, brightness scaling,
// blanking, and matching sync delay in front of the R/G/B DAC pins.
module vga_color_stage
  import vga_pkg::*;
#(
  parameter int IN_W        = 2,
  parameter int OUT_W       = 4,
  parameter int LVL_W       = 3,
  parameter int FADE_FRAMES = 4,
  parameter bit SYNC_POL    = SYNC_POL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             display_en,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             fade_out_req,
  input  logic             fade_in_req,
  output logic [OUT_W-1:0] R,
  output logic [OUT_W-1:0] G,
  output logic [OUT_W-1:0] B,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [LVL_W:0]   level,
  output logic             fade_busy
);

  localparam int   PW        = OUT_W + LVL_W + 1;
  localparam logic SYNC_IDLE = ~SYNC_POL;

  logic [IN_W-1:0]  code_in [3];
  logic [OUT_W-1:0] exp_d [3];
  logic [OUT_W-1:0] exp_q [3];
  logic [PW-1:0]    prod [3];
  logic [OUT_W-1:0] pix_d [3];
  logic [OUT_W-1:0] pix_q [3];
  logic [LVL_W:0]   lvl_q;
  logic             de_q;
  logic             hs1_q, vs1_q, hs2_q, vs2_q;

  vga_fade_ctrl #(
    .LVL_W       (LVL_W),
    .FADE_FRAMES (FADE_FRAMES),
    .SYNC_POL    (SYNC_POL)
  ) u_fade (
    .clk          (clk),
    .rst          (rst),
    .vsync_in     (vsync_in),
    .fade_out_req (fade_out_req),
    .fade_in_req  (fade_in_req),
    .level        (level),
    .fade_busy    (fade_busy)
  );

  assign code_in[0] = r_in;
  assign code_in[1] = g_in;
  assign code_in[2] = b_in;

  // Level is captured alongside the pixel so a step on a tick cycle only
  // affects pixels entering from the following cycle onward.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      exp_d[c] = OUT_W'(expand_color(MAX_COLOR_W'(code_in[c]), IN_W, OUT_W));
      prod[c]  = PW'(exp_q[c]) * PW'(lvl_q);
      pix_d[c] = de_q ? OUT_W'(prod[c] >> LVL_W) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        exp_q[c] <= '0;
        pix_q[c] <= '0;
      end
      lvl_q <= '0;
      de_q  <= 1'b0;
      hs1_q <= SYNC_IDLE;
      vs1_q <= SYNC_IDLE;
      hs2_q <= SYNC_IDLE;
      vs2_q <= SYNC_IDLE;
    end else begin
      for (int c = 0; c < 3; c++) begin
        exp_q[c] <= exp_d[c];
        pix_q[c] <= pix_d[c];
      end
      lvl_q <= level;
      de_q  <= display_en;
      hs1_q <= hsync_in;
      vs1_q <= vsync_in;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign R         = pix_q[0];
  assign G         = pix_q[1];
  assign B         = pix_q[2];
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;

endmodule

// File: tb/tb_vga_color_stage.sv
// Directed bench for vga_color_stage: pixel scoreboard plus fade/level checks.
module tb_vga_color_stage;

  logic       clk;
  logic       rst;
  logic       display_en;
  logic       hsync_in, vsync_in;
  logic [1:0] r_in, g_in, b_in;
  logic       fade_out_req, fade_in_req;
  logic [3:0] R, G, B;
  logic       hsync_out, vsync_out;
  logic [3:0] level;
  logic       fade_busy;

  typedef struct {
    int       cyc;
    int       id;
    logic [3:0] r, g, b;
    logic     hs, vs;
  } pix_t;

  pix_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   pix_id = 0;

  vga_color_stage dut (
    .clk          (clk),
    .rst          (rst),
    .display_en   (display_en),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .r_in         (r_in),
    .g_in         (g_in),
    .b_in         (b_in),
    .fade_out_req (fade_out_req),
    .fade_in_req  (fade_in_req),
    .R            (R),
    .G            (G),
    .B            (B),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .level        (level),
    .fade_busy    (fade_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each expected pixel appears exactly two cycles after it was driven.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc + 2 <= cyc) begin
      pix_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc + 2 != cyc ||
          {R, G, B, hsync_out, vsync_out} !== {e.r, e.g, e.b, e.hs, e.vs}) begin
        errors++;
        $display("FAIL pix%0d: got R=%b G=%b B=%b hs=%b vs=%b, expected R=%b G=%b B=%b hs=%b vs=%b",
                 e.id, R, G, B, hsync_out, vsync_out, e.r, e.g, e.b, e.hs, e.vs);
      end else begin
        $display("pix%0d: R=%b G=%b B=%b hs=%b vs=%b ok", e.id, R, G, B, hsync_out, vsync_out);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end else begin
      $display("%s: %0d ok", name, got);
    end
  endtask

  task automatic pix(input logic de, input logic [1:0] r, input logic [1:0] g, input logic [1:0] b,
                     input logic hs, input logic vs,
                     input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
    pix_t e;
    display_en = de; r_in = r; g_in = g; b_in = b; hsync_in = hs; vsync_in = vs;
    e.cyc = cyc; e.id = pix_id; e.r = er; e.g = eg; e.b = eb; e.hs = hs; e.vs = vs;
    pix_id++;
    q.push_back(e);
    next();
  endtask

  task automatic drain();
    hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (3) next();
  endtask

  task automatic tick();
    vsync_in = 1'b0;
    next();
    vsync_in = 1'b1;
    next();
    next();
  endtask

  task automatic req(input logic fo, input logic fi);
    fade_out_req = fo; fade_in_req = fi;
    next();
    fade_out_req = 1'b0; fade_in_req = 1'b0;
    next();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; display_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    r_in = '0; g_in = '0; b_in = '0; fade_out_req = 1'b0; fade_in_req = 1'b0;
    repeat (3) next();
    chk("reset_rgb", int'({R, G, B}), 0);
    chk("reset_hsync", int'(hsync_out), 1);
    chk("reset_vsync", int'(vsync_out), 1);
    chk("reset_level", int'(level), 8);
    chk("reset_busy", int'(fade_busy), 0);
    rst = 1'b0;
    next();

    // Expansion at full level, sync alignment, blanking.
    pix(1, 1, 2, 3, 1, 1, 4'b0101, 4'b1010, 4'b1111);
    pix(1, 1, 2, 3, 0, 1, 4'b0101, 4'b1010, 4'b1111);
    pix(1, 1, 2, 3, 1, 0, 4'b0101, 4'b1010, 4'b1111);
    pix(1, 0, 3, 1, 1, 1, 4'b0000, 4'b1111, 4'b0101);
    pix(0, 3, 3, 3, 1, 1, 4'b0000, 4'b0000, 4'b0000);
    pix(0, 3, 3, 3, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    pix(1, 3, 3, 3, 1, 1, 4'b1111, 4'b1111, 4'b1111);
    drain();
    chk("bright_level", int'(level), 8);
    chk("bright_busy", int'(fade_busy), 0);

    // Full fade-out: one level per four ticks.
    req(1, 0);
    chk("fo_busy", int'(fade_busy), 1);
    chk("fo_level0", int'(level), 8);
    for (int t = 1; t <= 32; t++) begin
      tick();
      chk($sformatf("fo_t%0d_level", t), int'(level), 8 - t / 4);
      if (t == 4) begin
        pix(1, 3, 2, 1, 1, 1, 4'd13, 4'd8, 4'd4);
        drain();
      end
      if (t == 16) begin
        pix(1, 3, 3, 3, 1, 1, 4'b0111, 4'b0111, 4'b0111);
        pix(1, 1, 2, 3, 0, 1, 4'd2, 4'd5, 4'd7);
        pix(0, 3, 3, 3, 1, 1, 4'd0, 4'd0, 4'd0);
        drain();
      end
    end
    chk("dark_busy", int'(fade_busy), 0);
    pix(1, 3, 3, 3, 1, 1, 4'd0, 4'd0, 4'd0);
    drain();
    tick();
    chk("dark_tick_level", int'(level), 0);

    // Simultaneous requests while dark: out wins and is a no-op.
    req(1, 1);
    chk("dark_both_busy", int'(fade_busy), 0);
    repeat (4) tick();
    chk("dark_both_level", int'(level), 0);

    // Full fade-in.
    req(0, 1);
    chk("fi_busy", int'(fade_busy), 1);
    for (int t = 1; t <= 32; t++) begin
      tick();
      chk($sformatf("fi_t%0d_level", t), int'(level), t / 4);
    end
    chk("fi_done_busy", int'(fade_busy), 0);

    // Simultaneous requests while bright: fades out.
    req(1, 1);
    chk("bright_both_busy", int'(fade_busy), 1);
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk($sformatf("fo2_t%0d_level", t), int'(level), 8 - t / 4);
    end
    repeat (2) tick();
    chk("fo2_partial_level", int'(level), 5);
    // Reversal clears the partial frame count; level continues from 5.
    req(0, 1);
    chk("rev_busy", int'(fade_busy), 1);
    chk("rev_level", int'(level), 5);
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk($sformatf("rev_t%0d_level", t), int'(level), 5 + t / 4);
    end
    chk("rev_done_busy", int'(fade_busy), 0);

    // Reset mid-fade with vsync held active.
    req(1, 0);
    repeat (20) tick();
    chk("mid_level", int'(level), 3);
    display_en = 1'b1; r_in = 2'd3; g_in = 2'd3; b_in = 2'd3;
    hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (3) next();
    chk("mid_r", int'(R), 5);
    chk("mid_vsync", int'(vsync_out), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rgb", int'({R, G, B}), 0);
    chk("arst_hsync", int'(hsync_out), 1);
    chk("arst_vsync", int'(vsync_out), 1);
    chk("arst_level", int'(level), 8);
    chk("arst_busy", int'(fade_busy), 0);
    repeat (2) next();
    rst = 1'b0;
    repeat (5) next();
    chk("post_rst_level", int'(level), 8);
    chk("post_rst_busy", int'(fade_busy), 0);
    req(1, 0);
    repeat (4) next();
    vsync_in = 1'b1;
    repeat (2) next();
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk($sformatf("post_rst_t%0d_level", t), int'(level), (t == 4) ? 7 : 8);
    end

    repeat (4) next();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
